// File: rtl/pe_feeder.sv
// rtl/pe_feeder.sv - weight/input vector buffer that streams both vectors to a downstream PE
//
// Loads two VEC_LEN-word vectors (weights, inputs) through a valid/ready port,
// then on start plays them out to a PE: one PE-reset cycle, VEC_LEN weight
// cycles, GAP idle cycles, VEC_LEN input cycles, and a one-cycle done pulse.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous active-low reset
//   s_valid   load word valid
//   s_ready   load word accepted this cycle (combinational)
//   s_kind    target buffer: 0 = weight, 1 = input
//   s_data    signed load word
//   start     request to stream both buffers (needs both buffers full)
//   busy      streaming run in progress
//   done      one-cycle pulse at the end of a run
//   pe_reset  active-high reset to the PE
//   pe_w      sign-extended weight stream
//   pe_in     sign-extended input stream
module pe_feeder #(
  parameter int DATA_W  = 8,
  parameter int VEC_LEN = 32,
  parameter int PE_W    = 16,
  parameter int GAP     = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_kind,
  input  logic [DATA_W-1:0] s_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pe_reset,
  output logic [PE_W-1:0]   pe_w,
  output logic [PE_W-1:0]   pe_in
);

  localparam int AW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam int CW = $clog2(VEC_LEN + 1);
  localparam logic [AW-1:0] K_LAST = AW'(VEC_LEN - 1);
  localparam logic [CW-1:0] FULL   = CW'(VEC_LEN);
  localparam logic [3:0]    G_LAST = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

  typedef enum logic [2:0] {IDLE, CLR, WGT, GAPS, INP, DONE} state_t;

  logic [DATA_W-1:0] wbuf [VEC_LEN];
  logic [DATA_W-1:0] ibuf [VEC_LEN];
  logic [CW-1:0]     wcnt, icnt;
  logic              w_full, i_full, wr;

  state_t            state, state_n;
  logic [AW-1:0]     k, k_n;
  logic [3:0]        g, g_n;
  logic              busy_n, done_n, pe_reset_n;
  logic [PE_W-1:0]   pe_w_n, pe_in_n;

  function automatic logic [PE_W-1:0] sext(input logic [DATA_W-1:0] d);
    return {{(PE_W-DATA_W){d[DATA_W-1]}}, d};
  endfunction

  assign w_full  = (wcnt == FULL);
  assign i_full  = (icnt == FULL);
  assign s_ready = (state == IDLE) && (s_kind ? !i_full : !w_full);
  assign wr      = s_valid && s_ready;

  always_ff @(posedge clk) begin
    if (reset && wr) begin
      if (s_kind) ibuf[icnt[AW-1:0]] <= s_data;
      else        wbuf[wcnt[AW-1:0]] <= s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || state == DONE) begin
      wcnt <= '0;
      icnt <= '0;
    end else if (wr) begin
      if (s_kind) icnt <= icnt + CW'(1);
      else        wcnt <= wcnt + CW'(1);
    end
  end

  // Outputs are computed for the state being entered and registered with it,
  // so each stream word appears in the same cycle as the state that owns it.
  always_comb begin
    state_n    = state;
    k_n        = k;
    g_n        = g;
    done_n     = 1'b0;
    pe_reset_n = 1'b0;
    pe_w_n     = '0;
    pe_in_n    = '0;
    case (state)
      IDLE: begin
        if (start && w_full && i_full) begin
          state_n    = CLR;
          pe_reset_n = 1'b1;
        end
      end
      CLR: begin
        state_n = WGT;
        k_n     = '0;
        pe_w_n  = sext(wbuf[0]);
      end
      WGT: begin
        if (k == K_LAST) begin
          k_n = '0;
          g_n = '0;
          if (GAP == 0) begin
            state_n = INP;
            pe_in_n = sext(ibuf[0]);
          end else begin
            state_n = GAPS;
          end
        end else begin
          k_n    = k + AW'(1);
          pe_w_n = sext(wbuf[k + AW'(1)]);
        end
      end
      GAPS: begin
        if (g == G_LAST) begin
          state_n = INP;
          pe_in_n = sext(ibuf[0]);
        end else begin
          g_n = g + 4'd1;
        end
      end
      INP: begin
        if (k == K_LAST) begin
          state_n = DONE;
          done_n  = 1'b1;
        end else begin
          k_n     = k + AW'(1);
          pe_in_n = sext(ibuf[k + AW'(1)]);
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      k        <= '0;
      g        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pe_reset <= 1'b1;
      pe_w     <= '0;
      pe_in    <= '0;
    end else begin
      state    <= state_n;
      k        <= k_n;
      g        <= g_n;
      busy     <= busy_n;
      done     <= done_n;
      pe_reset <= pe_reset_n;
      pe_w     <= pe_w_n;
      pe_in    <= pe_in_n;
    end
  end

endmodule

// File: tb/tb_pe_feeder.sv
// tb/tb_pe_feeder.sv - scoreboard bench for pe_feeder (GAP=1 and GAP=0 instances)
module tb_pe_feeder;

  localparam int V = 4;

  typedef struct {
    int          cyc;
    logic        pr;
    logic [15:0] w;
    logic [15:0] x;
    logic        dn;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_kind = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        start = 1'b0;
  logic        s_ready [2];
  logic        busy [2];
  logic        done [2];
  logic        pe_reset [2];
  logic [15:0] pe_w [2];
  logic [15:0] pe_in [2];

  int   cyc = 0;
  logic rst_at_edge = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   gaps [2];
  int   idle_at [2];

  logic [7:0] wq [$];
  logic [7:0] iq [$];
  exp_t       sb0 [$];
  exp_t       sb1 [$];

  pe_feeder #(.DATA_W(8), .VEC_LEN(V), .PE_W(16), .GAP(1)) dut_g1 (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready[0]),
    .s_kind(s_kind), .s_data(s_data), .start(start), .busy(busy[0]),
    .done(done[0]), .pe_reset(pe_reset[0]), .pe_w(pe_w[0]), .pe_in(pe_in[0])
  );

  pe_feeder #(.DATA_W(8), .VEC_LEN(V), .PE_W(16), .GAP(0)) dut_g0 (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready[1]),
    .s_kind(s_kind), .s_data(s_data), .start(start), .busy(busy[1]),
    .done(done[1]), .pe_reset(pe_reset[1]), .pe_w(pe_w[1]), .pe_in(pe_in[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= reset;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  function automatic logic [15:0] sx(input logic [7:0] d);
    int t;
    t = $signed(d);
    return t[15:0];
  endfunction

  function automatic void push_exp(input int d, input exp_t e);
    if (d == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endfunction

  // Expected per-cycle picture of a whole run, derived from the stream order:
  // one reset cycle, weights, gap zeros, inputs, done.
  function automatic void push_run(input int d, input int e);
    exp_t r;
    int   c;
    c = e + 1;
    r = '{cyc: c, pr: 1'b1, w: 16'h0, x: 16'h0, dn: 1'b0};
    push_exp(d, r);
    c++;
    for (int i = 0; i < V; i++) begin
      r = '{cyc: c, pr: 1'b0, w: sx(wq[i]), x: 16'h0, dn: 1'b0};
      push_exp(d, r);
      c++;
    end
    for (int i = 0; i < gaps[d]; i++) begin
      r = '{cyc: c, pr: 1'b0, w: 16'h0, x: 16'h0, dn: 1'b0};
      push_exp(d, r);
      c++;
    end
    for (int i = 0; i < V; i++) begin
      r = '{cyc: c, pr: 1'b0, w: 16'h0, x: sx(iq[i]), dn: 1'b0};
      push_exp(d, r);
      c++;
    end
    r = '{cyc: c, pr: 1'b0, w: 16'h0, x: 16'h0, dn: 1'b1};
    push_exp(d, r);
  endfunction

  task automatic monitor_dut(input int d);
    exp_t        e;
    logic        have;
    logic [35:0] got, exp;
    have = 1'b0;
    if (d == 0) begin
      while (sb0.size() > 0 && sb0[0].cyc < cyc) begin
        void'(sb0.pop_front());
        chk("stale_expect", 64'd1, 64'd0);
      end
      if (sb0.size() > 0 && sb0[0].cyc == cyc) begin e = sb0.pop_front(); have = 1'b1; end
    end else begin
      while (sb1.size() > 0 && sb1[0].cyc < cyc) begin
        void'(sb1.pop_front());
        chk("stale_expect", 64'd1, 64'd0);
      end
      if (sb1.size() > 0 && sb1[0].cyc == cyc) begin e = sb1.pop_front(); have = 1'b1; end
    end
    got = {1'b0, busy[d], done[d], pe_reset[d], pe_w[d], pe_in[d]};
    if (have) exp = {1'b0, 1'b1, e.dn, e.pr, e.w, e.x};
    else      exp = {1'b0, 1'b0, 1'b0, !rst_at_edge, 16'h0, 16'h0};
    chk($sformatf("outs_gap%0d(busy,done,pe_reset,pe_w,pe_in)", gaps[d]), 64'(got), 64'(exp));
  endtask

  always @(negedge clk) begin
    if (cyc >= 1) begin
      monitor_dut(0);
      monitor_dut(1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_idle(input int d);
    return cyc >= idle_at[d];
  endfunction

  task automatic load(input logic kind, input logic [7:0] d);
    bit rdy [2];
    s_valid = 1'b1;
    s_kind  = kind;
    s_data  = d;
    #1;
    for (int i = 0; i < 2; i++) begin
      rdy[i] = is_idle(i) && (kind ? (iq.size() < V) : (wq.size() < V));
      chk($sformatf("s_ready_gap%0d", gaps[i]), 64'(s_ready[i]), 64'(rdy[i]));
    end
    tick();
    if (rdy[0]) begin
      if (kind) iq.push_back(d);
      else      wq.push_back(d);
    end
    s_valid = 1'b0;
    s_data  = 8'($urandom);
  endtask

  task automatic do_start();
    int e;
    bit acc;
    e     = cyc;
    acc   = 1'b0;
    start = 1'b1;
    for (int d = 0; d < 2; d++) begin
      if (is_idle(d) && wq.size() == V && iq.size() == V) begin
        push_run(d, e);
        idle_at[d] = e + 3 + 2 * V + gaps[d];
        acc = 1'b1;
      end
    end
    tick();
    start = 1'b0;
    if (acc) begin
      wq.delete();
      iq.delete();
    end
  endtask

  task automatic wait_idle();
    while (cyc < idle_at[0] || cyc < idle_at[1]) tick();
  endtask

  task automatic load_random_interleaved();
    for (int i = 0; i < 2 * V; i++) begin
      load(1'(i % 2), 8'($urandom));
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) tick();
    end
  endtask

  initial begin
    int e;
    logic [7:0] bw [4];
    logic [7:0] bi [4];
    gaps[0] = 1;
    gaps[1] = 0;
    idle_at[0] = 0;
    idle_at[1] = 0;
    bw = '{8'hFE, 8'h6B, 8'hF0, 8'h36};
    bi = '{8'h35, 8'h02, 8'hD5, 8'h4F};

    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // basic run with the reference vectors
    for (int i = 0; i < V; i++) load(1'b0, bw[i]);
    for (int i = 0; i < V; i++) load(1'b1, bi[i]);
    do_start();
    wait_idle();
    tick();

    // early start, overflow, then accepted start with busy blocking
    for (int i = 0; i < V; i++) load(1'b0, 8'($urandom));
    for (int i = 0; i < V - 1; i++) load(1'b1, 8'($urandom));
    do_start();
    tick();
    load(1'b0, 8'hA5);
    load(1'b1, 8'($urandom));
    do_start();
    e = cyc - 1;
    while (cyc < e + 3) tick();
    load(1'b0, 8'h5A);
    do_start();
    load(1'b1, 8'h77);
    wait_idle();

    // interleaved random loading, consecutive runs
    for (int r = 0; r < 3; r++) begin
      load_random_interleaved();
      do_start();
      wait_idle();
    end

    // reset in the middle of the input phase
    load_random_interleaved();
    do_start();
    e = cyc - 1;
    while (cyc < e + 7) tick();
    reset = 1'b0;
    while (sb0.size() > 0 && sb0[$].cyc >= e + 8) void'(sb0.pop_back());
    while (sb1.size() > 0 && sb1[$].cyc >= e + 8) void'(sb1.pop_back());
    idle_at[0] = e + 8;
    idle_at[1] = e + 8;
    tick();
    reset = 1'b1;
    tick();
    do_start();
    repeat (3) tick();
    load_random_interleaved();
    do_start();
    wait_idle();
    repeat (3) tick();

    chk("sb_left_gap1", 64'(sb0.size()), 64'd0);
    chk("sb_left_gap0", 64'(sb1.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pe_feeder.md
PE_FEEDER -- requirements
Module: pe_feeder

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of one buffered weight or input word.
REQ-002 SHALL have parameter VEC_LEN, default 32: words per vector, identical for weights and inputs.
REQ-003 SHALL have parameter PE_W, default 16: width of the PE-side data ports; PE_W > DATA_W.
REQ-004 SHALL have parameter GAP, default 1: idle cycles between the weight phase and the input phase, with 0 <= GAP <= 15.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-007 SHALL have port s_valid, input, 1: the load word is valid.
REQ-008 SHALL have port s_ready, output, 1: the block accepts a load word this cycle.
REQ-009 SHALL have port s_kind, input, 1: selects the target buffer; 0 = weight buffer, 1 = input buffer.
REQ-010 SHALL have port s_data, input, DATA_W: signed load word.
REQ-011 SHALL have port start, input, 1: request to stream the buffered vectors to the PE.
REQ-012 SHALL have port busy, output, 1: a streaming run is in progress.
REQ-013 SHALL have port done, output, 1: one-cycle pulse when a run completes.
REQ-014 SHALL have port pe_reset, output, 1: active-high reset driven to the downstream PE.
REQ-015 SHALL have port pe_w, output, PE_W: weight stream driven to the PE.
REQ-016 SHALL have port pe_in, output, PE_W: input stream driven to the PE.

Function
REQ-017 SHALL hold two VEC_LEN x DATA_W buffers (weight, input), each with its own write counter (0..VEC_LEN).
REQ-018 SHALL drive s_ready = 1 only in IDLE while the buffer selected by s_kind is not full; a word SHALL be written on a cycle with s_valid & s_ready, at that buffer's counter index, and that counter SHALL then increment.
REQ-019 SHALL perform no write and change no counter while s_ready = 0, including when the target buffer is full and when busy = 1.
REQ-020 SHALL have FSM states IDLE, CLR, WGT, GAPS, INP, DONE.
REQ-021 SHALL go IDLE->CLR on start = 1 only when both counters equal VEC_LEN; otherwise start SHALL be ignored with no side effects.
REQ-022 SHALL go CLR->WGT after exactly 1 cycle, with pe_reset = 1 only in CLR.
REQ-023 SHALL stay in WGT for VEC_LEN cycles, driving pe_w = sign-extended weight[k] on the k-th cycle and pe_in = 0.
REQ-024 SHALL stay in GAPS for GAP cycles with pe_w = 0 and pe_in = 0; GAP = 0 SHALL skip GAPS entirely.
REQ-025 SHALL stay in INP for VEC_LEN cycles, driving pe_in = sign-extended input[k] on the k-th cycle and pe_w = 0.
REQ-026 SHALL spend 1 cycle in DONE with done = 1, clear both write counters, then return to IDLE; buffer contents need not be cleared.
REQ-027 SHALL assert busy in CLR, WGT, GAPS, INP and DONE, and deassert it in IDLE.
REQ-028 SHALL register all outputs except s_ready; with start sampled at edge T, the timing SHALL be:
  - CLR during cycle T+1;
  - weight k on pe_w at T+2+k;
  - input k on pe_in at T+2+VEC_LEN+GAP+k;
  - done at T+2+2*VEC_LEN+GAP.
REQ-029 SHALL ignore start, s_valid and s_data while busy = 1.
REQ-030 SHALL perform no arithmetic beyond sign extension of DATA_W to PE_W.

Reset
REQ-031 SHALL, on reset = 0 at a rising edge, enter IDLE with both counters 0, busy = 0, done = 0, pe_w = 0, pe_in = 0, and pe_reset = 1 for that cycle; pe_reset SHALL return to 0 on the first edge with reset = 1.
REQ-032 SHALL abort a run on reset asserted mid-run, with no done pulse, and require both buffers to be reloaded before the next start is accepted.

Verification
REQ-033 SHALL be verified for a basic run (VEC_LEN = 4, GAP = 1): load weights FE, 6B, F0, 36 and inputs 35, 02, D5, 4F, then start -> pe_reset for 1 cycle; pe_w = FFFE, 006B, FFF0, 0036; one zero cycle; pe_in = 0035, 0002, FFD5, 004F; done at start+11.
REQ-034 SHALL be verified for early start: start after 3 of 4 inputs loaded -> ignored, busy stays 0; after the 4th input is loaded, start is accepted.
REQ-035 SHALL be verified for overflow: a 5th weight offered with s_kind = 0 -> s_ready = 0 and the buffer is unchanged, while s_kind = 1 is still accepted.
REQ-036 SHALL be verified for interleaved loading: weights and inputs loaded in alternation with random s_valid gaps -> the stream order matches per-buffer write order.
REQ-037 SHALL be verified for reset mid-run: reset = 0 during INP -> next cycle busy = 0, pe_in = 0, pe_reset = 1, no done pulse, counters 0.
REQ-038 SHALL be verified for busy blocking and GAP = 0: start and s_valid pulsed while busy -> no effect; back-to-back runs with GAP = 0 -> pe_in[0] in the cycle immediately after the last pe_w.
